// File: rtl/id_ex_alu_issue.sv
// ---------------------------------------------------------------------------
// id_ex_alu_issue
//   ID/EX pipeline register for a MIPS-style integer pipeline. It captures the
//   decoded instruction from ID, produces the 4-bit ALUControl code and the
//   load/store/branch controls, and presents forwarded ALU operands to EX.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall, flush               hazard-unit hold / bubble requests (flush wins)
//   id_valid, id_opcode,       decoded ID-stage instruction fields and
//   id_funct, id_imm16,        register-file read data
//   id_rs_data, id_rt_data,
//   id_rt, id_rd
//   fwd_a_sel, fwd_b_sel       forwarding selects (00/11 reg, 01 EX/MEM, 10 MEM/WB)
//   ex_mem_result,             forwarded values
//   mem_wb_result
//   ex_valid .. ex_illegal     registered EX-stage controls
//   ex_data1, ex_data2,        combinational forwarded operands
//   ex_store_data
// ---------------------------------------------------------------------------
module id_ex_alu_issue #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [5:0]      id_opcode,
  input  logic [5:0]      id_funct,
  input  logic [15:0]     id_imm16,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [XLEN-1:0] mem_wb_result,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_data1,
  output logic [XLEN-1:0] ex_data2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_write_reg,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch_eq,
  output logic            ex_branch_ne,
  output logic            ex_illegal
);

  // ---------------- decode (combinational, from ID fields) ----------------
  logic [3:0]      ctrl_next;
  logic [4:0]      wr_next;
  logic            rw_next, mr_next, mw_next, beq_next, bne_next;
  logic            use_imm_next, zext_next, legal_next;
  logic [XLEN-1:0] imm_next;

  always_comb begin
    ctrl_next    = 4'b0000;
    wr_next      = 5'd0;
    rw_next      = 1'b0;
    mr_next      = 1'b0;
    mw_next      = 1'b0;
    beq_next     = 1'b0;
    bne_next     = 1'b0;
    use_imm_next = 1'b0;
    zext_next    = 1'b0;
    legal_next   = 1'b1;
    case (id_opcode)
      6'b000000: begin
        wr_next = id_rd;
        rw_next = 1'b1;
        case (id_funct)
          6'b100000, 6'b100001: ctrl_next = 4'b0010;
          6'b100010, 6'b100011: ctrl_next = 4'b0110;
          6'b100100:            ctrl_next = 4'b0000;
          6'b100101:            ctrl_next = 4'b0001;
          6'b100111:            ctrl_next = 4'b1100;
          6'b101010:            ctrl_next = 4'b0111;
          default:              legal_next = 1'b0;
        endcase
      end
      6'b001000, 6'b001001: begin
        ctrl_next = 4'b0010; use_imm_next = 1'b1; wr_next = id_rt; rw_next = 1'b1;
      end
      6'b001010: begin
        ctrl_next = 4'b0111; use_imm_next = 1'b1; wr_next = id_rt; rw_next = 1'b1;
      end
      6'b001100: begin
        ctrl_next = 4'b0000; use_imm_next = 1'b1; zext_next = 1'b1;
        wr_next = id_rt; rw_next = 1'b1;
      end
      6'b001101: begin
        ctrl_next = 4'b0001; use_imm_next = 1'b1; zext_next = 1'b1;
        wr_next = id_rt; rw_next = 1'b1;
      end
      6'b100011: begin
        ctrl_next = 4'b0010; use_imm_next = 1'b1; mr_next = 1'b1;
        wr_next = id_rt; rw_next = 1'b1;
      end
      6'b101011: begin
        ctrl_next = 4'b0010; use_imm_next = 1'b1; mw_next = 1'b1;
      end
      6'b000100: begin ctrl_next = 4'b0110; beq_next = 1'b1; end
      6'b000101: begin ctrl_next = 4'b0110; bne_next = 1'b1; end
      default:   legal_next = 1'b0;
    endcase
    // An unsupported instruction must not leave any partial control behind.
    if (!legal_next) begin
      ctrl_next    = 4'b0000;
      wr_next      = 5'd0;
      rw_next      = 1'b0;
      use_imm_next = 1'b0;
      zext_next    = 1'b0;
    end
    imm_next = zext_next ? {{(XLEN-16){1'b0}}, id_imm16}
                         : {{(XLEN-16){id_imm16[15]}}, id_imm16};
  end

  // ---------------- ID/EX register ----------------
  logic            valid_reg, rw_reg, mr_reg, mw_reg, beq_reg, bne_reg;
  logic            ill_reg, use_imm_reg;
  logic [3:0]      ctrl_reg;
  logic [4:0]      wr_reg;
  logic [XLEN-1:0] rs_data_reg, rt_data_reg, imm_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      ctrl_reg    <= 4'b0000;
      wr_reg      <= 5'd0;
      rw_reg      <= 1'b0;
      mr_reg      <= 1'b0;
      mw_reg      <= 1'b0;
      beq_reg     <= 1'b0;
      bne_reg     <= 1'b0;
      ill_reg     <= 1'b0;
      use_imm_reg <= 1'b0;
      rs_data_reg <= '0;
      rt_data_reg <= '0;
      imm_reg     <= '0;
    end else if (flush) begin
      // Bubble: data registers are don't-care once every control is cleared.
      valid_reg   <= 1'b0;
      ctrl_reg    <= 4'b0000;
      wr_reg      <= 5'd0;
      rw_reg      <= 1'b0;
      mr_reg      <= 1'b0;
      mw_reg      <= 1'b0;
      beq_reg     <= 1'b0;
      bne_reg     <= 1'b0;
      ill_reg     <= 1'b0;
      use_imm_reg <= 1'b0;
    end else if (!stall) begin
      valid_reg   <= id_valid;
      rs_data_reg <= id_rs_data;
      rt_data_reg <= id_rt_data;
      imm_reg     <= imm_next;
      ctrl_reg    <= id_valid ? ctrl_next    : 4'b0000;
      wr_reg      <= id_valid ? wr_next      : 5'd0;
      rw_reg      <= id_valid & rw_next;
      mr_reg      <= id_valid & mr_next & legal_next;
      mw_reg      <= id_valid & mw_next & legal_next;
      beq_reg     <= id_valid & beq_next & legal_next;
      bne_reg     <= id_valid & bne_next & legal_next;
      ill_reg     <= id_valid & ~legal_next;
      use_imm_reg <= id_valid & use_imm_next;
    end
  end

  // ---------------- forwarding muxes (act on held data during stall) ----------------
  logic [XLEN-1:0] opnd [2];
  logic [1:0]      fsel [2];
  logic [XLEN-1:0] fwd  [2];

  assign opnd[0] = rs_data_reg;
  assign opnd[1] = rt_data_reg;
  assign fsel[0] = fwd_a_sel;
  assign fsel[1] = fwd_b_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] = (FWD_EN && fsel[gi] == 2'b01) ? ex_mem_result :
                       (FWD_EN && fsel[gi] == 2'b10) ? mem_wb_result :
                                                       opnd[gi];
    end
  endgenerate

  assign ex_valid       = valid_reg;
  assign ex_alu_control = ctrl_reg;
  assign ex_write_reg   = wr_reg;
  assign ex_reg_write   = rw_reg & valid_reg;
  assign ex_mem_read    = mr_reg;
  assign ex_mem_write   = mw_reg;
  assign ex_branch_eq   = beq_reg;
  assign ex_branch_ne   = bne_reg;
  assign ex_illegal     = ill_reg;
  assign ex_data1       = fwd[0];
  assign ex_store_data  = fwd[1];
  assign ex_data2       = use_imm_reg ? imm_reg : fwd[1];

endmodule
